// File: rtl/io_bus_pkg.sv
// io_bus_pkg
// Shared definitions for the memory-mapped IO responder: register byte
// offsets on the CPU IO bus and the state encoding of the button debounce FSM.
package io_bus_pkg;

    // Register byte offsets, decoded from io_addr[7:0]
    localparam logic [7:0] IO_LED      = 8'h00;
    localparam logic [7:0] IO_SEG_RDY  = 8'h04;
    localparam logic [7:0] IO_SEG_DATA = 8'h08;
    localparam logic [7:0] IO_SWX_VLD  = 8'h0C;
    localparam logic [7:0] IO_SWX_DATA = 8'h10;
    localparam logic [7:0] IO_CNT      = 8'h14;

    // Debounce FSM: the IDLE states hold a stable debounced level, and the
    // WAIT states count cycles in which the input disagrees with that level.
    typedef enum logic [1:0] {
        DB_IDLE_LO = 2'b00,
        DB_WAIT_HI = 2'b01,
        DB_IDLE_HI = 2'b10,
        DB_WAIT_LO = 2'b11
    } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronizes a raw asynchronous button, debounces it and emits a one-cycle
// press pulse on each accepted low-to-high transition of the debounced level.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   btn   - raw asynchronous button input
//   press - one-cycle pulse, high in the cycle before the debounced level rises
// A clean rise on btn shows up as press 2 + DEBOUNCE cycles later.
module btn_debounce
    import io_bus_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             sync1_r;
    logic             sync2_r;
    db_state_e        state_r;
    db_state_e        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // FSM state and disagreement counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DB_IDLE_LO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: any agreeing cycle in a WAIT state abandons the count
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            DB_IDLE_LO: begin
                cnt_s = CNT_ZERO;
                if (sync2_r) begin
                    state_s = DB_WAIT_HI;
                end else begin
                    state_s = DB_IDLE_LO;
                end
            end
            DB_WAIT_HI: begin
                if (!sync2_r) begin
                    state_s = DB_IDLE_LO;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DB_IDLE_HI;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = DB_WAIT_HI;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            DB_IDLE_HI: begin
                cnt_s = CNT_ZERO;
                if (!sync2_r) begin
                    state_s = DB_WAIT_LO;
                end else begin
                    state_s = DB_IDLE_HI;
                end
            end
            DB_WAIT_LO: begin
                if (sync2_r) begin
                    state_s = DB_IDLE_HI;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DB_IDLE_LO;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = DB_WAIT_LO;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = DB_IDLE_LO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output logic: press marks the cycle whose edge flips the level high
    always_comb begin
        press = 1'b0;
        case (state_r)
            DB_WAIT_HI: begin
                if (sync2_r && (cnt_r == CNT_LAST)) begin
                    press = 1'b1;
                end else begin
                    press = 1'b0;
                end
            end
            default: press = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder
// Peripheral-side responder on the CPU memory-mapped IO bus. Holds the LED
// and 7-segment registers, a switch-capture handshake driven by a debounced
// confirm button, a display-ready handshake and a free-running cycle counter.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   io_addr  - byte offset of the access
//   io_dout  - CPU write data
//   io_we    - CPU write strobe, one cycle per store
//   io_din   - read data to the CPU, combinational from io_addr
//   sw       - raw switches, sampled on a button press
//   btn      - raw asynchronous confirm button
//   led      - LED register
//   seg_data - 7-segment display value
module io_bus_responder
    import io_bus_pkg::*;
#(
    parameter int SW_W     = 16,
    parameter int DEBOUNCE = 16,
    parameter int SEG_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      io_addr,
    input  logic [31:0]     io_dout,
    input  logic            io_we,
    output logic [31:0]     io_din,
    input  logic [SW_W-1:0] sw,
    input  logic            btn,
    output logic [SW_W-1:0] led,
    output logic [31:0]     seg_data
);

    localparam int HOLD_W = (SEG_HOLD > 1) ? $clog2(SEG_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SEG_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    logic              press_s;
    logic              led_we_s;
    logic              seg_we_s;
    logic              swx_clr_s;

    logic [SW_W-1:0]   led_r;
    logic [31:0]       seg_data_r;
    logic [31:0]       seg_data_s;
    logic              seg_rdy_r;
    logic              seg_rdy_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
    logic              vld_r;
    logic              vld_s;
    logic              ovr_r;
    logic              ovr_s;
    logic [SW_W-1:0]   swx_data_r;
    logic [SW_W-1:0]   swx_data_s;
    logic [31:0]       cnt_r;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press_s)
    );

    assign led      = led_r;
    assign seg_data = seg_data_r;

    // Write strobe decode
    always_comb begin
        led_we_s  = io_we && (io_addr == IO_LED);
        seg_we_s  = io_we && (io_addr == IO_SEG_DATA);
        swx_clr_s = io_we && (io_addr == IO_SWX_VLD);
    end

    // Display handshake: a write is only accepted while seg_rdy is high, then
    // seg_rdy stays low for SEG_HOLD cycles (load SEG_HOLD-1, release at zero).
    always_comb begin
        seg_data_s = seg_data_r;
        seg_rdy_s  = seg_rdy_r;
        hold_s     = hold_r;
        if (seg_we_s && seg_rdy_r) begin
            seg_data_s = io_dout;
            seg_rdy_s  = 1'b0;
            hold_s     = HOLD_LOAD;
        end else if (!seg_rdy_r) begin
            if (hold_r == HOLD_ZERO) begin
                seg_rdy_s = 1'b1;
            end else begin
                hold_s = hold_r - HOLD_ONE;
            end
        end else begin
            seg_rdy_s = 1'b1;
        end
    end

    // Switch capture handshake: a SWX_VLD write clears first, so a press in
    // the same cycle sees an empty slot and captures fresh data.
    always_comb begin
        vld_s      = vld_r;
        ovr_s      = ovr_r;
        swx_data_s = swx_data_r;
        if (swx_clr_s) begin
            vld_s = 1'b0;
            ovr_s = 1'b0;
        end else begin
            vld_s = vld_r;
            ovr_s = ovr_r;
        end
        if (press_s) begin
            if (vld_s) begin
                ovr_s = 1'b1;
            end else begin
                vld_s      = 1'b1;
                swx_data_s = sw;
            end
        end else begin
            swx_data_s = swx_data_r;
        end
    end

    // Register bank; reset wins over any write or capture in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r      <= {SW_W{1'b0}};
            seg_data_r <= 32'h0000_0000;
            seg_rdy_r  <= 1'b1;
            hold_r     <= HOLD_ZERO;
            vld_r      <= 1'b0;
            ovr_r      <= 1'b0;
            swx_data_r <= {SW_W{1'b0}};
            cnt_r      <= 32'h0000_0000;
        end else begin
            if (led_we_s) begin
                led_r <= io_dout[SW_W-1:0];
            end
            seg_data_r <= seg_data_s;
            seg_rdy_r  <= seg_rdy_s;
            hold_r     <= hold_s;
            vld_r      <= vld_s;
            ovr_r      <= ovr_s;
            swx_data_r <= swx_data_s;
            cnt_r      <= cnt_r + 32'h0000_0001;
        end
    end

    // Read mux: combinational, no side effects
    always_comb begin
        io_din = 32'h0000_0000;
        case (io_addr)
            IO_SEG_RDY:  io_din = {31'h0000_0000, seg_rdy_r};
            IO_SWX_VLD:  io_din = {30'h0000_0000, ovr_r, vld_r};
            IO_SWX_DATA: io_din[SW_W-1:0] = swx_data_r;
            IO_CNT:      io_din = cnt_r;
            default:     io_din = 32'h0000_0000;
        endcase
    end

endmodule
